// File: rtl/vga_pkg.sv
// Shared VGA timing constants and star-prep types.
package vga_pkg;

  localparam int unsigned HTOTAL  = 1600;
  localparam int unsigned VTOTAL  = 525;
  localparam int unsigned HACTIVE = 640;

  typedef struct packed {
    logic       valid;
    logic [7:0] level;
    logic [9:0] y;
    logic [9:0] x;
  } star_entry_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    SCAN
  } prep_state_t;

endpackage

// File: rtl/star_line_buf.sv
// One-line pixel level buffer: single write port, single registered read port.
module star_line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Plain synchronous RAM so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/star_line_prep.sv
// Scans the star table for the next scanline into a back line buffer and
// replays the front buffer pixel-by-pixel to the renderer.
module star_line_prep #(
  parameter int unsigned STAR_COUNT = 64,
  parameter int unsigned LINE_PIX   = vga_pkg::HACTIVE,
  parameter int unsigned HTOTAL     = vga_pkg::HTOTAL,
  parameter int unsigned VTOTAL     = vga_pkg::VTOTAL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [10:0]                   hcount,
  input  logic [9:0]                    vcount,
  input  logic                          tbl_we,
  input  logic [$clog2(STAR_COUNT)-1:0] tbl_addr,
  input  logic [28:0]                   tbl_wdata,
  input  logic [15:0]                   flicker_mask,
  output logic                          star_on,
  output logic [7:0]                    star_level,
  output logic                          init_busy
);
  import vga_pkg::*;

  localparam int unsigned TBL_AW  = $clog2(STAR_COUNT);
  localparam int unsigned PIX_AW  = $clog2(LINE_PIX);
  localparam int unsigned IDX_MAX = (LINE_PIX > STAR_COUNT) ? LINE_PIX : STAR_COUNT;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

  prep_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [9:0]       ty_q;
  logic             front_sel;

  logic [27:0]           tbl_mem [STAR_COUNT];
  logic [STAR_COUNT-1:0] tbl_valid;
  logic [27:0]           tbl_rd_q;
  logic                  rd_vld_q;
  logic [3:0]            rd_mask_idx;
  star_entry_t           rd_ent;

  logic              out_vld;
  logic              out_sel;
  logic [9:0]        pix;
  logic              pix_act;
  logic              rep_re;
  logic              clr_we;
  logic              init_we;
  logic              rd_issue;
  logic              scan_we;
  logic [PIX_AW-1:0] pix_addr;

  logic              a_we, b_we;
  logic [PIX_AW-1:0] a_waddr, b_waddr;
  logic [7:0]        a_wdata, b_wdata;
  logic [7:0]        a_rdata, b_rdata;
  logic [7:0]        level_c;

  assign pix      = hcount[10:1];
  assign pix_act  = pix < 10'(LINE_PIX);
  assign pix_addr = PIX_AW'(pix);
  assign rep_re   = ~hcount[0] & pix_act;
  assign clr_we   = hcount[0] & pix_act;
  assign init_we  = (state == INIT);
  assign rd_issue = (state == SCAN) && (idx < IDX_W'(STAR_COUNT));

  // Table payload RAM; a read racing a host write to the same entry sees old data.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_mem[tbl_addr] <= tbl_wdata[27:0];
    if (rd_issue) tbl_rd_q <= tbl_mem[TBL_AW'(idx)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_valid <= '0;
    end else if (tbl_we) begin
      tbl_valid[tbl_addr] <= tbl_wdata[28];
    end
  end

  // Sequencer: buffer clear after reset, then one table scan per line start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      idx       <= '0;
      ty_q      <= '0;
      init_busy <= 1'b1;
      front_sel <= 1'b0;
    end else begin
      if (hcount == 11'(HTOTAL - 1)) front_sel <= ~front_sel;
      case (state)
        INIT: begin
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(LINE_PIX - 1)) begin
            state     <= IDLE;
            init_busy <= 1'b0;
            idx       <= '0;
          end
        end
        IDLE: begin
          if (hcount == 11'd0) begin
            state <= SCAN;
            idx   <= '0;
            ty_q  <= (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
          end
        end
        SCAN: begin
          // The extra count past the last entry is its write slot.
          if (idx == IDX_W'(STAR_COUNT)) state <= IDLE;
          else                           idx   <= idx + IDX_W'(1);
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q    <= 1'b0;
      rd_mask_idx <= '0;
      out_vld     <= 1'b0;
      out_sel     <= 1'b0;
    end else begin
      rd_vld_q    <= rd_issue && tbl_valid[TBL_AW'(idx)];
      rd_mask_idx <= idx[3:0];
      if (state == INIT) begin
        out_vld <= 1'b0;
      end else if (!hcount[0]) begin
        out_vld <= pix_act;
        out_sel <= front_sel;
      end
    end
  end

  assign rd_ent  = star_entry_t'({rd_vld_q, tbl_rd_q});
  assign scan_we = rd_ent.valid && (rd_ent.y == ty_q) && (rd_ent.x < 10'(LINE_PIX)) &&
                   flicker_mask[rd_mask_idx];

  // Write-port steering: init clears both, front gets clear-behind, back gets scan.
  always_comb begin
    a_we    = 1'b0;
    a_waddr = pix_addr;
    a_wdata = 8'h00;
    b_we    = 1'b0;
    b_waddr = pix_addr;
    b_wdata = 8'h00;
    if (init_we) begin
      a_we    = 1'b1;
      a_waddr = PIX_AW'(idx);
      b_we    = 1'b1;
      b_waddr = PIX_AW'(idx);
    end else if (front_sel) begin
      a_we    = scan_we;
      a_waddr = PIX_AW'(rd_ent.x);
      a_wdata = rd_ent.level;
      b_we    = clr_we;
    end else begin
      a_we    = clr_we;
      b_we    = scan_we;
      b_waddr = PIX_AW'(rd_ent.x);
      b_wdata = rd_ent.level;
    end
  end

  star_line_buf #(.DEPTH(LINE_PIX), .AW(PIX_AW)) u_buf_a (
    .clk   (clk),
    .we    (a_we),
    .waddr (a_waddr),
    .wdata (a_wdata),
    .re    (rep_re),
    .raddr (pix_addr),
    .rdata (a_rdata)
  );

  star_line_buf #(.DEPTH(LINE_PIX), .AW(PIX_AW)) u_buf_b (
    .clk   (clk),
    .we    (b_we),
    .waddr (b_waddr),
    .wdata (b_wdata),
    .re    (rep_re),
    .raddr (pix_addr),
    .rdata (b_rdata)
  );

  // Outputs come straight from the RAM read registers, qualified by flops.
  assign level_c    = out_sel ? b_rdata : a_rdata;
  assign star_level = out_vld ? level_c : 8'h00;
  assign star_on    = out_vld && (level_c != 8'h00);

endmodule

// File: tb/tb_star_line_prep.sv
// Directed bench for star_line_prep: drives VGA counters line by line and checks replayed pixels.
module tb_star_line_prep;

  localparam int LP = 640;
  localparam int HT = 1600;

  logic        clk;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        tbl_we;
  logic [5:0]  tbl_addr;
  logic [28:0] tbl_wdata;
  logic [15:0] flicker_mask;
  logic        star_on;
  logic [7:0]  star_level;
  logic        init_busy;

  int vec  = 0;
  int errs = 0;
  int stray;
  int bad_on;
  logic [7:0] la [LP];
  logic [7:0] lb [LP];
  logic       oa [LP];

  star_line_prep dut (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_wdata    (tbl_wdata),
    .flicker_mask (flicker_mask),
    .star_on      (star_on),
    .star_level   (star_level),
    .init_busy    (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] star(input logic [7:0] lv, input int y, input int x);
    return {1'b1, lv, 10'(y), 10'(x)};
  endfunction

  // Pixel errors of the last captured line against a single expected lit pixel (px<0: blank).
  function automatic int line_errs(input int px, input logic [7:0] lv);
    int n;
    logic [7:0] e;
    n = stray + bad_on;
    for (int p = 0; p < LP; p++) begin
      e = (p == px) ? lv : 8'h00;
      if (la[p] !== e) n++;
      if (lb[p] !== e) n++;
      if (oa[p] !== (e != 8'h00)) n++;
    end
    return n;
  endfunction

  task automatic tbl_write(input logic [5:0] a, input logic [28:0] d);
    tbl_we    = 1'b1;
    tbl_addr  = a;
    tbl_wdata = d;
    @(posedge clk); #1;
    tbl_we    = 1'b0;
  endtask

  // Runs one full line with vcount=v, capturing both samples of each pixel.
  task automatic run_line(input int v, input int wr_h, input logic [5:0] wr_a, input logic [28:0] wr_d);
    vcount = 10'(v);
    stray  = 0;
    bad_on = 0;
    for (int h = 0; h < HT; h++) begin
      hcount = 11'(h);
      if (h == wr_h) begin
        tbl_we    = 1'b1;
        tbl_addr  = wr_a;
        tbl_wdata = wr_d;
      end
      if (h >= 1 && h <= 2 * LP) begin
        if (h % 2 == 1) begin
          la[(h - 1) / 2] = star_level;
          oa[(h - 1) / 2] = star_on;
        end else begin
          lb[(h - 2) / 2] = star_level;
        end
      end else if (star_level !== 8'h00 || star_on !== 1'b0) begin
        stray++;
      end
      if (star_on !== (star_level != 8'h00)) bad_on++;
      @(posedge clk); #1;
      tbl_we = 1'b0;
    end
    hcount = 11'd1400;
  endtask

  task automatic test_reset();
    int on_seen;
    int n;
    on_seen = 0;
    reset   = 1'b1;
    hcount  = 11'd1400;
    vcount  = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (star_level !== 8'h00 || star_on !== 1'b0 || init_busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_state: level=%h on=%b busy=%b, want 00 0 1", star_level, star_on, init_busy);
    end
    reset = 1'b0;
    for (int k = 1; k <= 640; k++) begin
      hcount = (k == 300) ? 11'd0 : 11'd1400;
      @(posedge clk); #1;
      if (star_on !== 1'b0 || star_level !== 8'h00) on_seen++;
      if (k == 639) begin
        vec++;
        if (init_busy !== 1'b1) begin
          errs++;
          $display("FAIL init_busy_clk639: got %b want 1", init_busy);
        end
      end
    end
    hcount = 11'd1400;
    vec++;
    if (init_busy !== 1'b0) begin
      errs++;
      $display("FAIL init_busy_clk640: got %b want 0", init_busy);
    end
    vec++;
    if (on_seen != 0) begin
      errs++;
      $display("FAIL init_outputs_quiet: %0d lit cycles, want 0", on_seen);
    end
    run_line(0, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL first_line_blank: %0d pixel errors, want 0", n);
    end
    run_line(1, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL second_buffer_blank: %0d pixel errors, want 0", n);
    end
  endtask

  task automatic test_single_star();
    int n;
    tbl_write(6'd0, star(8'hC0, 10, 100));
    tbl_write(6'd4, star(8'h11, 12, 639));
    tbl_write(6'd6, star(8'h22, 13, 640));
    run_line(9, -1, 6'd0, 29'd0);
    run_line(10, -1, 6'd0, 29'd0);
    vec++;
    if (la[100] !== 8'hC0 || lb[100] !== 8'hC0 || oa[100] !== 1'b1) begin
      errs++;
      $display("FAIL single_px100: got %h/%h on=%b want c0/c0 on=1", la[100], lb[100], oa[100]);
    end
    n = line_errs(100, 8'hC0);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL single_line10_image: %0d pixel errors, want 0", n);
    end
    run_line(11, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL single_line11_blank: %0d pixel errors, want 0", n);
    end
    run_line(12, -1, 6'd0, 29'd0);
    n = line_errs(639, 8'h11);
    vec++;
    if (la[639] !== 8'h11 || n != 0) begin
      errs++;
      $display("FAIL edge_px639: got %h with %0d errors, want 11 with 0", la[639], n);
    end
    run_line(13, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL offscreen_x640: %0d pixel errors, want 0", n);
    end
  endtask

  task automatic test_overlap();
    int n;
    tbl_write(6'd3, star(8'h40, 20, 50));
    tbl_write(6'd7, star(8'h90, 20, 50));
    run_line(19, -1, 6'd0, 29'd0);
    run_line(20, -1, 6'd0, 29'd0);
    n = line_errs(50, 8'h90);
    vec++;
    if (la[50] !== 8'h90 || n != 0) begin
      errs++;
      $display("FAIL overlap_high_index: got %h with %0d errors, want 90 with 0", la[50], n);
    end
    run_line(21, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (la[50] !== 8'h00 || n != 0) begin
      errs++;
      $display("FAIL overlap_cleared: got %h with %0d errors, want 00 with 0", la[50], n);
    end
  endtask

  task automatic test_wrap();
    int n;
    tbl_write(6'd8, star(8'h77, 0, 5));
    run_line(524, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL wrap_line524_blank: %0d pixel errors, want 0", n);
    end
    run_line(0, -1, 6'd0, 29'd0);
    n = line_errs(5, 8'h77);
    vec++;
    if (la[5] !== 8'h77 || n != 0) begin
      errs++;
      $display("FAIL wrap_line0: got %h with %0d errors, want 77 with 0", la[5], n);
    end
  endtask

  task automatic test_flicker();
    int n;
    flicker_mask = 16'hFFDF;
    tbl_write(6'd21, star(8'h55, 30, 10));
    run_line(29, -1, 6'd0, 29'd0);
    run_line(30, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL flicker_masked: %0d pixel errors, want 0", n);
    end
    flicker_mask = 16'hFFFF;
    run_line(29, -1, 6'd0, 29'd0);
    run_line(30, -1, 6'd0, 29'd0);
    n = line_errs(10, 8'h55);
    vec++;
    if (la[10] !== 8'h55 || n != 0) begin
      errs++;
      $display("FAIL flicker_unmasked: got %h with %0d errors, want 55 with 0", la[10], n);
    end
  endtask

  task automatic test_host_collision();
    int n;
    tbl_write(6'd2, star(8'h33, 40, 200));
    // Entry 2 is read by the scan during hcount 3; overwrite it on that clk.
    run_line(39, 3, 6'd2, star(8'h44, 41, 201));
    run_line(40, -1, 6'd0, 29'd0);
    n = line_errs(200, 8'h33);
    vec++;
    if (la[200] !== 8'h33 || n != 0) begin
      errs++;
      $display("FAIL collision_old_data: got %h with %0d errors, want 33 with 0", la[200], n);
    end
    run_line(41, -1, 6'd0, 29'd0);
    n = line_errs(201, 8'h44);
    vec++;
    if (la[201] !== 8'h44 || n != 0) begin
      errs++;
      $display("FAIL collision_new_data: got %h with %0d errors, want 44 with 0", la[201], n);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    tbl_write(6'd9, star(8'hBB, 51, 400));
    tbl_write(6'd10, star(8'hAA, 50, 10));
    run_line(49, -1, 6'd0, 29'd0);
    vcount = 10'd50;
    for (int h = 0; h < 22; h++) begin
      hcount = 11'(h);
      @(posedge clk); #1;
    end
    hcount = 11'd22;
    vec++;
    if (star_level !== 8'hAA || star_on !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset_px10: got %h on=%b want aa on=1", star_level, star_on);
    end
    reset  = 1'b1;
    hcount = 11'd1400;
    #1;
    vec++;
    if (star_level !== 8'h00 || star_on !== 1'b0 || init_busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_immediate: level=%h on=%b busy=%b want 00 0 1", star_level, star_on, init_busy);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (640) @(posedge clk);
    #1;
    vec++;
    if (init_busy !== 1'b0) begin
      errs++;
      $display("FAIL reinit_done: busy=%b want 0", init_busy);
    end
    run_line(50, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL post_reset_line50: %0d pixel errors, want 0", n);
    end
    run_line(51, -1, 6'd0, 29'd0);
    n = line_errs(-1, 8'h00);
    vec++;
    if (n != 0) begin
      errs++;
      $display("FAIL post_reset_line51: %0d pixel errors, want 0", n);
    end
  endtask

  initial begin
    reset        = 1'b1;
    hcount       = 11'd1400;
    vcount       = 10'd0;
    tbl_we       = 1'b0;
    tbl_addr     = 6'd0;
    tbl_wdata    = 29'd0;
    flicker_mask = 16'hFFFF;
    test_reset();
    test_single_star();
    test_overlap();
    test_wrap();
    test_flicker();
    test_host_collision();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
